// File: rtl/psl_job_sequencer.sv
// PSL-side job-control driver: issues RESET then START to the AFU, tracks running/done/error
// and reports one registered status word plus the START-to-done cycle count per job.
module psl_job_sequencer #(
  parameter int ODD_PARITY  = 1,
  parameter int RST_TIMEOUT = 1024,
  parameter int RUN_TIMEOUT = 2**24,
  parameter int CNT_W       = 32
) (
  input  logic             ha_pclock,
  input  logic             reset,
  input  logic             job_req,
  input  logic [0:63]      job_ea,
  input  logic             job_abort,
  output logic             job_ready,
  output logic             ha_jval,
  output logic [0:7]       ha_jcom,
  output logic             ha_jcompar,
  output logic [0:63]      ha_jea,
  output logic             ha_jeapar,
  input  logic             ah_jrunning,
  input  logic             ah_jdone,
  input  logic [0:63]      ah_jerror,
  output logic             job_status_valid,
  output logic [0:2]       job_status,
  output logic [0:63]      job_error,
  output logic [0:CNT_W-1] job_cycles
);

  localparam logic             PAR_ODD    = (ODD_PARITY != 0);
  localparam logic             RUN_TMO_EN = (RUN_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] RST_TMO    = CNT_W'(RST_TIMEOUT);
  localparam logic [CNT_W-1:0] RUN_TMO    = CNT_W'(RUN_TIMEOUT);

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_AFU_ERR = 3'd1;
  localparam logic [2:0] ST_RST_TMO = 3'd2;
  localparam logic [2:0] ST_RUN_TMO = 3'd3;
  localparam logic [2:0] ST_ABORTED = 3'd4;
  localparam logic [2:0] ST_NO_RUN  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_ISSUE, S_RST_WAIT, S_START_ISSUE, S_RUN_WAIT, S_DONE_WAIT, S_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [0:63]      ea_q, ea_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [2:0]       pend_q, pend_d;

  logic             job_ready_q, job_ready_d;
  logic             jval_q, jval_d;
  logic [0:7]       jcom_q, jcom_d;
  logic             jcompar_q, jcompar_d;
  logic [0:63]      jea_q, jea_d;
  logic             jeapar_q, jeapar_d;
  logic             sv_q, sv_d;
  logic [0:2]       status_q, status_d;
  logic [0:63]      error_q, error_d;
  logic [0:CNT_W-1] cycles_q, cycles_d;

  logic [2:0]       res;
  logic [0:63]      res_err;
  logic [CNT_W-1:0] rcnt_inc, run_inc;
  logic             run_seen;

  always_comb begin
    state_d  = state_q;
    ea_d     = ea_q;
    rcnt_d   = rcnt_q;
    run_d    = run_q;
    pend_d   = pend_q;
    res      = ST_OK;
    res_err  = '0;
    rcnt_inc = rcnt_q + 1'b1;
    run_inc  = (&run_q) ? run_q : run_q + 1'b1;
    run_seen = (state_q == S_DONE_WAIT) || ah_jrunning;

    case (state_q)
      S_IDLE: begin
        if (job_req) begin
          ea_d    = job_ea;
          pend_d  = ST_OK;
          run_d   = '0;
          state_d = S_RST_ISSUE;
        end
      end
      S_RST_ISSUE: begin
        rcnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = S_RST_WAIT;
      end
      // A pending run-timeout/abort ends the job once the AFU has been reset again.
      S_RST_WAIT: begin
        rcnt_d = rcnt_inc;
        if (ah_jdone) begin
          if (pend_q != ST_OK) begin
            res     = pend_q;
            state_d = S_REPORT;
          end else begin
            state_d = S_START_ISSUE;
          end
        end else if (rcnt_inc == RST_TMO) begin
          res     = (pend_q != ST_OK) ? pend_q : ST_RST_TMO;
          state_d = S_REPORT;
        end
      end
      // The START cycle itself counts, so the job length includes both endpoints.
      S_START_ISSUE: begin
        run_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = S_RUN_WAIT;
      end
      S_RUN_WAIT, S_DONE_WAIT: begin
        run_d = run_inc;
        if (ah_jdone) begin
          res_err = ah_jerror;
          res     = !run_seen ? ST_NO_RUN : ((|ah_jerror) ? ST_AFU_ERR : ST_OK);
          state_d = S_REPORT;
        end else if (job_abort) begin
          pend_d  = ST_ABORTED;
          state_d = S_RST_ISSUE;
        end else if (RUN_TMO_EN && (run_inc == RUN_TMO)) begin
          pend_d  = ST_RUN_TMO;
          state_d = S_RST_ISSUE;
        end else if (ah_jrunning) begin
          state_d = S_DONE_WAIT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    job_ready_d = (state_d == S_IDLE);
    jval_d      = (state_d == S_RST_ISSUE) || (state_d == S_START_ISSUE);
    jcom_d      = 8'h00;
    jea_d       = '0;
    if (state_d == S_RST_ISSUE) begin
      jcom_d = 8'h80;
    end else if (state_d == S_START_ISSUE) begin
      jcom_d = 8'h90;
      jea_d  = ea_d;
    end
    jcompar_d = (^jcom_d) ^ PAR_ODD;
    jeapar_d  = (^jea_d) ^ PAR_ODD;
    sv_d      = (state_d == S_REPORT);
    status_d  = sv_d ? res     : status_q;
    error_d   = sv_d ? res_err : error_q;
    cycles_d  = sv_d ? run_d   : cycles_q;
  end

  always_ff @(posedge ha_pclock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ea_q        <= '0;
      rcnt_q      <= '0;
      run_q       <= '0;
      pend_q      <= ST_OK;
      job_ready_q <= 1'b1;
      jval_q      <= 1'b0;
      jcom_q      <= '0;
      jcompar_q   <= PAR_ODD;
      jea_q       <= '0;
      jeapar_q    <= PAR_ODD;
      sv_q        <= 1'b0;
      status_q    <= '0;
      error_q     <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      ea_q        <= ea_d;
      rcnt_q      <= rcnt_d;
      run_q       <= run_d;
      pend_q      <= pend_d;
      job_ready_q <= job_ready_d;
      jval_q      <= jval_d;
      jcom_q      <= jcom_d;
      jcompar_q   <= jcompar_d;
      jea_q       <= jea_d;
      jeapar_q    <= jeapar_d;
      sv_q        <= sv_d;
      status_q    <= status_d;
      error_q     <= error_d;
      cycles_q    <= cycles_d;
    end
  end

  assign job_ready        = job_ready_q;
  assign ha_jval          = jval_q;
  assign ha_jcom          = jcom_q;
  assign ha_jcompar       = jcompar_q;
  assign ha_jea           = jea_q;
  assign ha_jeapar        = jeapar_q;
  assign job_status_valid = sv_q;
  assign job_status       = status_q;
  assign job_error        = error_q;
  assign job_cycles       = cycles_q;

endmodule
